// File: rtl/sound_cmd_pkg.sv
// Shared types and constants for the sound command queue.
package sound_cmd_pkg;

    localparam int CMD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        ACK,
        GAP
    } irq_state_t;

    // Occupancy counter must represent 0..2**depth_log2 inclusive.
    function automatic int level_w(input int depth_log2);
        return $clog2((1 << depth_log2) + 1);
    endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Pointer/level command FIFO with a registered head output.
module sound_cmd_fifo
    import sound_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic [CMD_W-1:0]                  i_din,
    output logic [CMD_W-1:0]                  o_dout,
    output logic [level_w(DEPTH_LOG2)-1:0]    o_level,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = level_w(DEPTH_LOG2);

    logic [CMD_W-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [CMD_W-1:0]      r_dout;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [DEPTH_LOG2-1:0] w_rd_next;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop_ok);
    assign w_rd_next = r_rd_ptr + DEPTH_LOG2'(1);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // r_dout tracks the entry that will be at the head after this edge;
            // when the FIFO drains it keeps the last popped byte.
            if (w_push_ok && (w_empty || (w_pop_ok && r_level == LW'(1)))) begin
                r_dout <= i_din;
            end else if (w_pop_ok && r_level > LW'(1)) begin
                r_dout <= r_mem[w_rd_next];
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/sound_cmd_queue.sv
// Main-CPU to sound-CPU command FIFO with IRQ sequencer.
// Optional statistics outputs are enabled with SOUND_CMD_QUEUE_STATS_EN.
module sound_cmd_queue
    import sound_cmd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int IRQ_GAP    = 16
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  W3A08n,
    input  logic [CMD_W-1:0]      DB_in,
    input  logic                  latch_cs_n,
    input  logic                  snd_rd,
    input  logic                  ovf_clr,
    output logic [CMD_W-1:0]      cmd_q,
    output logic                  irq_n,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf
`ifdef SOUND_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]           stat_push,
    output logic [7:0]            stat_drop,
    output logic [DEPTH_LOG2:0]   stat_maxlvl
`endif
);

    localparam int LW = level_w(DEPTH_LOG2);

    logic          r_w3a08n_d;
    logic          r_cs_n_d;
    logic          r_armed;
    logic          r_ovf;
    logic          r_irq_n;
    irq_state_t    r_state;
    irq_state_t    w_state_next;
    logic [7:0]    r_gap_cnt;
    logic [7:0]    w_gap_next;

    logic          w_push;
    logic          w_cs_rise;
    logic          w_rd_qual;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;

    assign w_push    = !r_w3a08n_d && W3A08n;
    assign w_cs_rise = !r_cs_n_d && latch_cs_n;
    assign w_rd_qual = !latch_cs_n && snd_rd;
    assign w_pop     = w_cs_rise && r_armed && !w_empty;
    assign w_drop    = w_push && w_full && !w_pop;

    sound_cmd_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (RSTn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (DB_in),
        .o_dout  (cmd_q),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Edge detectors load live inputs during reset so release is edge-free.
    always_ff @(posedge clk) begin
        r_w3a08n_d <= W3A08n;
        r_cs_n_d   <= latch_cs_n;
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_armed <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_cs_rise) begin
                r_armed <= 1'b0;
            end else if (w_rd_qual) begin
                r_armed <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_irq_n   <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_next;
            r_irq_n   <= (r_state == IDLE) || (r_state == GAP);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gap_next   = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_level != '0) begin
                    w_state_next = PEND;
                end
            end
            PEND: begin
                if (w_rd_qual) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (w_pop) begin
                    w_state_next = GAP;
                    w_gap_next   = 8'(IRQ_GAP - 1);
                end else if (w_cs_rise) begin
                    w_state_next = PEND;
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = (w_level != '0) ? PEND : IDLE;
                end else begin
                    w_gap_next = r_gap_cnt - 8'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign irq_n = r_irq_n;
    assign level = w_level;
    assign ovf   = r_ovf;

`ifdef SOUND_CMD_QUEUE_STATS_EN
    logic [15:0]   r_stat_push;
    logic [7:0]    r_stat_drop;
    logic [LW-1:0] r_stat_maxlvl;

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            r_stat_push   <= '0;
            r_stat_drop   <= '0;
            r_stat_maxlvl <= '0;
        end else begin
            if (w_push && !w_drop && r_stat_push != '1) begin
                r_stat_push <= r_stat_push + 16'd1;
            end
            if (w_drop && r_stat_drop != '1) begin
                r_stat_drop <= r_stat_drop + 8'd1;
            end
            if (w_level > r_stat_maxlvl) begin
                r_stat_maxlvl <= w_level;
            end
        end
    end

    assign stat_push   = r_stat_push;
    assign stat_drop   = r_stat_drop;
    assign stat_maxlvl = r_stat_maxlvl;
`endif

endmodule

// File: tb/tb_sound_cmd_queue.sv
// Scoreboard bench for sound_cmd_queue: directed scenarios plus a random phase.
`timescale 1ns/1ps
module tb_sound_cmd_queue;

    localparam int DEPTH_LOG2 = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int IRQ_GAP    = 16;

    logic                clk = 1'b0;
    logic                RSTn;
    logic                W3A08n;
    logic [7:0]          DB_in;
    logic                latch_cs_n;
    logic                snd_rd;
    logic                ovf_clr;
    logic [7:0]          cmd_q;
    logic                irq_n;
    logic [DEPTH_LOG2:0] level;
    logic                ovf;
`ifdef SOUND_CMD_QUEUE_STATS_EN
    logic [15:0]         stat_push;
    logic [7:0]          stat_drop;
    logic [DEPTH_LOG2:0] stat_maxlvl;
`endif

    sound_cmd_queue #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .IRQ_GAP   (IRQ_GAP)
    ) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .W3A08n     (W3A08n),
        .DB_in      (DB_in),
        .latch_cs_n (latch_cs_n),
        .snd_rd     (snd_rd),
        .ovf_clr    (ovf_clr),
        .cmd_q      (cmd_q),
        .irq_n      (irq_n),
        .level      (level),
        .ovf        (ovf)
`ifdef SOUND_CMD_QUEUE_STATS_EN
        ,
        .stat_push  (stat_push),
        .stat_drop  (stat_drop),
        .stat_maxlvl(stat_maxlvl)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_ovf;
    logic [7:0] exp_q[$];
    bit         mon_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the byte the sound CPU sees on the first read cycle of each access.
    always @(posedge clk) begin
        #1;
        if (latch_cs_n) begin
            mon_seen = 1'b0;
        end else if (snd_rd && !mon_seen && RSTn) begin
            mon_seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_data: got 0x%0h with no expected read queued", cmd_q);
            end else begin
                check("read_data", {24'd0, cmd_q}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [7:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : m_last;
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic m_pop();
        if (m_q.size() > 0) m_last = m_q.pop_front();
    endtask

    task automatic check_state();
        check("level", 32'(level), 32'(m_q.size()));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        RSTn = 1'b0; W3A08n = 1'b1; latch_cs_n = 1'b1; snd_rd = 1'b0; ovf_clr = 1'b0; DB_in = 8'h00;
        repeat (3) @(negedge clk);
        RSTn = 1'b1;
        m_q.delete(); exp_q.delete(); m_last = 8'h00; m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit clr);
        @(negedge clk); W3A08n = 1'b0; DB_in = b;
        @(negedge clk); W3A08n = 1'b1; ovf_clr = clr;
        @(negedge clk); ovf_clr = 1'b0;
        if (clr) m_ovf = 1'b0;
        m_push(b);
    endtask

    task automatic read_cmd(input int hold);
        exp_q.push_back(m_head());
        @(negedge clk); latch_cs_n = 1'b0; snd_rd = 1'b1;
        repeat (hold) @(negedge clk);
        snd_rd = 1'b0;
        @(negedge clk); latch_cs_n = 1'b1;
        @(negedge clk);
        m_pop();
    endtask

    task automatic push_pop_same(input logic [7:0] b);
        exp_q.push_back(m_head());
        @(negedge clk); W3A08n = 1'b0; DB_in = b; latch_cs_n = 1'b0; snd_rd = 1'b1;
        @(negedge clk); snd_rd = 1'b0;
        @(negedge clk); W3A08n = 1'b1; latch_cs_n = 1'b1;
        @(negedge clk);
        m_pop();
        m_push(b);
    endtask

    task automatic wait_irq_low(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!irq_n) break;
            @(negedge clk);
        end
        check(name, 32'(irq_n), 32'd0);
    endtask

    // Count cycles irq_n stays high after a pop until it re-asserts.
    task automatic measure_gap(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (irq_n) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        logic [7:0] burst [3];
        burst[0] = 8'h01; burst[1] = 8'h0F; burst[2] = 8'h09;

        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("rst_cmd_q", 32'(cmd_q), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // single command
        push_byte(8'h8A, 1'b0);
        check("irq_n_push_1cyc", 32'(irq_n), 32'd1);
        @(negedge clk);
        check("irq_n_push_1cyc", 32'(irq_n), 32'd1);
        @(negedge clk);
        check("irq_n_push_2cyc", 32'(irq_n), 32'd0);
        read_cmd(2);
        check_state();
        repeat (IRQ_GAP + 3) @(negedge clk);
        check("irq_n_idle", 32'(irq_n), 32'd1);
        check("cmd_q_hold", 32'(cmd_q), 32'h8A);

        // burst of three, reads spaced out
        for (int i = 0; i < 3; i++) begin
            push_byte(burst[i], 1'b0);
            @(negedge clk);
        end
        check_state();
        for (int i = 0; i < 3; i++) begin
            wait_irq_low("irq_assert_burst");
            repeat (20) @(negedge clk);
            read_cmd(2);
            check_state();
            if (i < 2) begin
                measure_gap(gap);
                check("irq_gap_min", 32'(gap >= IRQ_GAP), 32'd1);
                check("irq_gap_max", 32'(gap <= IRQ_GAP + 1), 32'd1);
                repeat (10) @(negedge clk);
            end
        end
        repeat (IRQ_GAP + 3) @(negedge clk);
        check("irq_n_after_burst", 32'(irq_n), 32'd1);
        check("cmd_q_final_burst", 32'(cmd_q), 32'h09);

        // overflow, clear, set-beats-clear, full push+pop
        do_reset();
        for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i), 1'b0);
        check_state();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0; m_ovf = 1'b0;
        check_state();
        push_byte(8'h77, 1'b1);
        check_state();
        @(negedge clk); ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0; m_ovf = 1'b0;
        check_state();
        push_pop_same(8'h55);
        check_state();
        while (m_q.size() > 0) begin
            read_cmd(1);
            check_state();
        end

        // reset in the middle of a read
        do_reset();
        push_byte(8'h21, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h23, 1'b0);
        check_state();
        exp_q.push_back(m_head());
        @(negedge clk); latch_cs_n = 1'b0; snd_rd = 1'b1;
        @(negedge clk); RSTn = 1'b0; snd_rd = 1'b0;
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
        m_q.delete(); m_last = 8'h00; m_ovf = 1'b0;
        @(negedge clk);
        check("rstmid_level", 32'(level), 32'd0);
        check("rstmid_irq_n", 32'(irq_n), 32'd1);
        check("rstmid_cmd_q", 32'(cmd_q), 32'd0);
        push_byte(8'h31, 1'b0);
        @(negedge clk); latch_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check_state();

        // window selected without a read qualifier
        push_byte(8'h32, 1'b0);
        wait_irq_low("irq_assert_noqual");
        @(negedge clk); latch_cs_n = 1'b0; snd_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noqual_irq_n", 32'(irq_n), 32'd0);
        end
        latch_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("noqual_irq_n_after", 32'(irq_n), 32'd0);
        check_state();
        read_cmd(1);
        read_cmd(2);
        check_state();

        // random mix against the queue model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 5) push_byte(8'($urandom), ($urandom_range(0, 7) == 0));
            else if (op < 9) read_cmd(int'($urandom_range(1, 3)));
            else push_pop_same(8'($urandom));
            check_state();
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
